// File: rtl/sift_stream_pkg.sv
// Shared definitions for the SIFT pixel stream: pixel width, frame geometry defaults, reader FSM states.
// No logic; constants and types only.
// Imported by the FIFO reader and the Gaussian/DoG line buffers so frame geometry stays consistent.
package sift_stream_pkg;

    localparam int PIX_W         = 8;
    localparam int IMG_W_DEFAULT = 320;
    localparam int IMG_H_DEFAULT = 240;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/pix_skid2.sv
// Two-entry output buffer: holds returned FIFO bytes together with their frame position.
// Latency: an entry written in cycle M is presented on out_dat/out_vld in cycle M+1.
// Backpressure: head holds while out_rdy=0; writer must not write when full (buf_cnt exposed for credit).
module pix_skid2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [DW-1:0] in_dat,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_dat,
    output logic [1:0]    buf_cnt
);

    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] mem_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          pop;

    assign out_vld = (cnt_q != 2'd0);
    assign out_dat = mem_q[rd_ptr_q];
    assign buf_cnt = cnt_q;

    // Write at the tail, retire the head on a handshake; simultaneous write+retire keeps the count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pop      = out_vld & out_rdy;
        if (in_vld) begin
            mem_d[wr_ptr_q] = in_dat;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + {1'b0, in_vld} - {1'b0, pop};
    end

    // Buffer state registers; storage is cleared so pix reads zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_pixel_reader.sv
// Pops exactly IMG_W*IMG_H bytes per frame from the pixel FIFO and emits a framed valid/ready stream (sof/eol/eof).
// Latency: pop in cycle M -> pixel valid in cycle M+2 (empty buffer); sustains 1 pixel/cycle.
// Backpressure: pix_ready low holds the head stable; pops stop once the 2-entry buffer plus in-flight byte is full.
// Optional: define FIFO_PIXEL_READER_UNDERRUN_CNT_EN to add a saturating 16-bit underrun_cnt output.
module fifo_pixel_reader
    import sift_stream_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEFAULT,
    parameter int IMG_H = IMG_H_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             fifo_empty,
    input  logic [PIX_W-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic [PIX_W-1:0] pix,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             sof,
    output logic             eol,
    output logic             eof,
    output logic             busy
`ifdef FIFO_PIXEL_READER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]      underrun_cnt
`endif
);

    localparam int TOTAL = IMG_W * IMG_H;
    localparam int IW    = $clog2(TOTAL + 1);
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int DW    = RW + CW + PIX_W;
    localparam logic [IW-1:0] TOTAL_C  = IW'(TOTAL);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] issued_q, issued_d;
    logic          inflight_q, inflight_d;
    logic [CW-1:0] wcol_q, wcol_d;
    logic [RW-1:0] wrow_q, wrow_d;
    logic [DW-1:0] wr_dat, head_dat;
    logic [CW-1:0] head_col;
    logic [RW-1:0] head_row;
    logic [1:0]    buf_cnt;
    logic [2:0]    occ;
    logic          xfer, credit_ok, can_pop;

    // Each buffered byte carries its own frame position, so markers follow the head entry exactly.
    assign wr_dat = {wrow_q, wcol_q, fifo_dout};

    pix_skid2 #(.DW(DW)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (inflight_q),
        .in_dat  (wr_dat),
        .out_vld (pix_valid),
        .out_rdy (pix_ready),
        .out_dat (head_dat),
        .buf_cnt (buf_cnt)
    );

    assign head_row = head_dat[DW-1 -: RW];
    assign head_col = head_dat[PIX_W +: CW];
    assign pix      = head_dat[PIX_W-1:0];

    // Credit: buffered + in-flight bytes, minus the slot the head frees this cycle; keeps full rate without overflow.
    always_comb begin
        xfer      = pix_valid & pix_ready;
        occ       = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, xfer};
        credit_ok = (occ < 3'd2);
        can_pop   = (state_q == RUN) && (issued_q < TOTAL_C) && credit_ok;
    end

    // FSM outputs: pop request and markers decoded from the head entry's position.
    always_comb begin
        fifo_rd_en = can_pop & ~fifo_empty;
        busy       = (state_q == RUN);
        sof        = pix_valid && (head_row == '0) && (head_col == '0);
        eol        = pix_valid && (head_col == COL_LAST);
        eof        = eol && (head_row == ROW_LAST);
    end

    // FSM next state: start is only seen in IDLE; the eof handshake ends the frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start)        state_d = RUN;
            RUN:  if (xfer && eof)  state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Pop counter and write-side position; both restart when a frame is accepted.
    always_comb begin
        issued_d   = issued_q;
        wcol_d     = wcol_q;
        wrow_d     = wrow_q;
        inflight_d = fifo_rd_en;
        if ((state_q == IDLE) && start) begin
            issued_d = '0;
            wcol_d   = '0;
            wrow_d   = '0;
        end else begin
            if (fifo_rd_en) begin
                issued_d = issued_q + IW'(1);
            end
            if (inflight_q) begin
                if (wcol_q == COL_LAST) begin
                    wcol_d = '0;
                    wrow_d = (wrow_q == ROW_LAST) ? '0 : wrow_q + RW'(1);
                end else begin
                    wcol_d = wcol_q + CW'(1);
                end
            end
        end
    end

    // State and counter registers; reset drops any byte still in flight from the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            issued_q   <= '0;
            inflight_q <= 1'b0;
            wcol_q     <= '0;
            wrow_q     <= '0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            inflight_q <= inflight_d;
            wcol_q     <= wcol_d;
            wrow_q     <= wrow_d;
        end
    end

`ifdef FIFO_PIXEL_READER_UNDERRUN_CNT_EN
    logic [15:0] und_q, und_d;

    // Count cycles a pop was wanted but the FIFO had nothing; saturates, survives across frames.
    always_comb begin
        und_d = und_q;
        if (can_pop && fifo_empty && (und_q != 16'hFFFF)) begin
            und_d = und_q + 16'd1;
        end
    end

    // Underrun counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            und_q <= 16'd0;
        end else begin
            und_q <= und_d;
        end
    end

    assign underrun_cnt = und_q;
`endif

endmodule

// File: tb/tb_fifo_pixel_reader.sv
module tb_fifo_pixel_reader;

    localparam int W = 4;
    localparam int H = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pix_ready = 1'b1;
    logic       fifo_empty;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_rd_en, pix_valid, sof, eol, eof, busy;
    logic [7:0] pix;
`ifdef FIFO_PIXEL_READER_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    always #5 clk = ~clk;

    fifo_pixel_reader #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .pix        (pix),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .sof        (sof),
        .eol        (eol),
        .eof        (eof),
        .busy       (busy)
`ifdef FIFO_PIXEL_READER_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // FIFO model: one-cycle read latency, indexed by push/pop counters.
    logic [7:0] fmem [256];
    int push_cnt = 0;
    int pop_cnt  = 0;
    assign fifo_empty = (push_cnt == pop_cnt);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= fmem[pop_cnt % 256];
            pop_cnt   <= pop_cnt + 1;
        end
    end

    // Scoreboard of expected {pix, sof, eol, eof}.
    logic [10:0] emem [1024];
    logic [10:0] e_head;
    int exp_wr = 0;
    int exp_rd = 0;
    int rd_log [1024];
    int tr_log [1024];
    int rd_cnt = 0;
    int tr_cnt = 0;
    int viol   = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_rd_en) begin
                rd_log[rd_cnt % 1024] = cyc;
                rd_cnt++;
                if (fifo_empty) viol++;
            end
            if (pix_valid) begin
                if (exp_rd < exp_wr) begin
                    e_head = emem[exp_rd % 1024];
                    chk("pix", {24'd0, pix}, {24'd0, e_head[10:3]});
                    chk("sof_eol_eof", {29'd0, sof, eol, eof}, {29'd0, e_head[2:0]});
                end else begin
                    chk("spurious_valid", {31'd0, pix_valid}, 32'd0);
                end
                if (pix_ready) begin
                    tr_log[tr_cnt % 1024] = cyc;
                    tr_cnt++;
                    exp_rd++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
        #1;
    endtask

    task automatic push_fifo(input logic [7:0] b);
        fmem[push_cnt % 256] = b;
        push_cnt++;
    endtask

    task automatic push_exp(input logic [7:0] b, input int i);
        emem[exp_wr % 1024] = {b, (i == 0), ((i % W) == W - 1), (i == W * H - 1)};
        exp_wr++;
    endtask

    task automatic push_frame(input logic [7:0] base);
        for (int i = 0; i < W * H; i++) begin
            push_fifo(base + 8'(i));
            push_exp(base + 8'(i), i);
        end
    endtask

    int start_cyc;

    task automatic start_frame();
        tick();
        start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_tr(input int target, input string tag);
        int k = 0;
        while (tr_cnt < target && k < 200) begin
            samp();
            k++;
        end
        chk(tag, {31'd0, (tr_cnt >= target)}, 32'd1);
    endtask

    task automatic wait_eof(input string tag);
        logic found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            samp();
            if (pix_valid && pix_ready && eof) begin
                found = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, found}, 32'd1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rd_en"}, {31'd0, fifo_rd_en}, 32'd0);
        chk({tag, "_valid"}, {31'd0, pix_valid}, 32'd0);
        chk({tag, "_pix"}, {24'd0, pix}, 32'd0);
        chk({tag, "_markers"}, {29'd0, sof, eol, eof}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    int r0, r1, t0;

    initial begin
        // Reset with a full FIFO: nothing may be popped or presented.
        push_frame(8'h10);
        tick();
        tick();
        samp();
        chk_idle_outputs("in_rst");
        tick();
        rst = 1'b0;
        samp();
        chk_idle_outputs("post_rst");

        // Full-rate frame.
        r0 = rd_cnt;
        t0 = tr_cnt;
        start_frame();
        samp();
        chk("f1_busy_after_start", {31'd0, busy}, 32'd1);
        wait_eof("f1_eof_seen");
        samp();
        chk("f1_busy_after_eof", {31'd0, busy}, 32'd0);
        chk("f1_pops", rd_cnt - r0, 32'd8);
        chk("f1_xfers", tr_cnt - t0, 32'd8);
        chk("f1_first_pop_lat", rd_log[r0 % 1024] - start_cyc, 32'd1);
        chk("f1_pop_to_valid", tr_log[t0 % 1024] - rd_log[r0 % 1024], 32'd2);
        chk("f1_back_to_back", tr_log[(t0 + 7) % 1024] - tr_log[t0 % 1024], 32'd7);

        // Backpressure: 5-cycle stall after two transfers.
        push_frame(8'h20);
        r0 = rd_cnt;
        t0 = tr_cnt;
        start_frame();
        wait_tr(t0 + 2, "bp_reach_2");
        tick();
        pix_ready = 1'b0;
        r1 = rd_cnt;
        repeat (5) samp();
        chk("bp_stall_pops_le2", {31'd0, (rd_cnt - r1 <= 2)}, 32'd1);
        chk("bp_valid_in_stall", {31'd0, pix_valid}, 32'd1);
        tick();
        pix_ready = 1'b1;
        wait_eof("bp_eof_seen");
        chk("bp_pops", rd_cnt - r0, 32'd8);

        // Underrun: FIFO holds 3 bytes, then stays empty for 3 cycles.
        for (int i = 0; i < W * H; i++) push_exp(8'h30 + 8'(i), i);
        for (int i = 0; i < 3; i++) push_fifo(8'h30 + 8'(i));
        r0 = rd_cnt;
        start_frame();
        for (int k = 0; k < 50 && rd_cnt < r0 + 3; k++) samp();
        chk("ur_three_pops", rd_cnt - r0, 32'd3);
        for (int k = 0; k < 3; k++) begin
            samp();
            chk("ur_gap_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        end
        tick();
        for (int i = 3; i < W * H; i++) push_fifo(8'h30 + 8'(i));
        wait_eof("ur_eof_seen");
        chk("ur_pops", rd_cnt - r0, 32'd8);
`ifdef FIFO_PIXEL_READER_UNDERRUN_CNT_EN
        chk("ur_underrun_cnt", {16'd0, underrun_cnt}, 32'd3);
`endif

        // Start ignored mid-frame, then a back-to-back frame.
        push_frame(8'h40);
        push_frame(8'h50);
        r0 = rd_cnt;
        t0 = tr_cnt;
        start_frame();
        wait_tr(t0 + 3, "b2b_reach_3");
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_eof("b2b_eof_a");
        chk("b2b_pops_a", rd_cnt - r0, 32'd8);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        samp();
        chk("b2b_busy_b", {31'd0, busy}, 32'd1);
        wait_eof("b2b_eof_b");
        chk("b2b_pops_total", rd_cnt - r0, 32'd16);

        // Mid-frame reset after 5 transfers, then a fresh frame.
        push_frame(8'h60);
        t0 = tr_cnt;
        start_frame();
        wait_tr(t0 + 5, "mr_reach_5");
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push_cnt = pop_cnt;
        exp_wr = exp_rd;
        samp();
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_valid", {31'd0, pix_valid}, 32'd0);
        chk("mr_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("mr_xfers_before_rst", tr_cnt - t0, 32'd5);
        push_frame(8'h70);
        r0 = rd_cnt;
        start_frame();
        wait_eof("mr_eof_seen");
        chk("mr_pops", rd_cnt - r0, 32'd8);

        samp();
        chk("rd_while_empty", viol, 32'd0);
        chk("scoreboard_left", exp_wr - exp_rd, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
